// File: rtl/rotary_input_conditioner_pkg.sv
// Shared definitions for the rotary encoder input conditioner.
//   deb_state_e           : per-channel debounce FSM encoding
//   GLITCH_W              : width of the diagnostic glitch counter
//   DEFAULT_STABLE_CYCLES : default hold time a new level must survive
//   DEFAULT_CNT_W         : default debounce counter width
//   sat_add_glitch()      : saturating add of up to three glitch events
package rotary_input_conditioner_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

  localparam int GLITCH_W              = 8;
  localparam int DEFAULT_STABLE_CYCLES = 50000;
  localparam int DEFAULT_CNT_W         = 16;

  // Adds 0..3 events to the counter and pins the result at all-ones
  // instead of wrapping.
  function automatic logic [GLITCH_W-1:0] sat_add_glitch(
    input logic [GLITCH_W-1:0] base,
    input logic [1:0]          events
  );
    logic [GLITCH_W:0] sum;
    sum = {1'b0, base} + {{(GLITCH_W - 1){1'b0}}, events};
    if (sum[GLITCH_W]) begin
      return {GLITCH_W{1'b1}};
    end
    return sum[GLITCH_W-1:0];
  endfunction

endpackage

// File: rtl/rotary_input_conditioner_debounce_channel.sv
// One debounced input channel: 2-flop synchroniser followed by a hold-time
// filter FSM.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous pin
//   level    : accepted (debounced) level
//   rise     : high in the cycle level goes 0->1
//   fall     : high in the cycle level goes 1->0
//   glitch   : high in a cycle where a pending change was abandoned
module debounce_channel
  import rotary_input_conditioner_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // State register: synchroniser, FSM, counter, level and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: a differing sample opens a pending window; the level only
  // flips once STABLE_CYCLES consecutive samples have disagreed with it.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
          state_d = ST_PENDING;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PENDING: begin
        if (sync2_q == lvl_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          lvl_d   = ~lvl_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: edge strobes are registered alongside lvl_q so they line up
  // with the level change; glitch is reported in the abandoning cycle.
  always_comb begin
    glitch = 1'b0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (state_q == ST_PENDING) begin
      if (sync2_q == lvl_q) begin
        glitch = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        rise_d = ~lvl_q;
        fall_d = lvl_q;
      end
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/rotary_input_conditioner.sv
// Rotary encoder front end: debounces channel A, channel B and the push
// switch, and keeps a saturating count of rejected transitions.
//   clk, rst       : system clock, synchronous active-high reset
//   rot_a_raw      : encoder channel A pin (async)
//   rot_b_raw      : encoder channel B pin (async)
//   rot_press_raw  : push-switch pin (async), 1 = pressed
//   clear_glitch   : strobe zeroing glitch_count
//   rot_a, rot_b   : debounced channel levels
//   press          : debounced switch level
//   press_pulse    : one cycle, aligned with press rising
//   release_pulse  : one cycle, aligned with press falling
//   glitch_count   : saturating count of rejected transitions
module rotary_input_conditioner
  import rotary_input_conditioner_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rot_a_raw,
  input  logic                rot_b_raw,
  input  logic                rot_press_raw,
  input  logic                clear_glitch,
  output logic                rot_a,
  output logic                rot_b,
  output logic                press,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [GLITCH_W-1:0] glitch_count
);

  logic level_a, level_b, level_p;
  logic rise_p, fall_p;
  logic glitch_a, glitch_b, glitch_p;
  // The counter downstream only needs A/B levels, not their edge strobes.
  logic [3:0] ab_edges_unused;

  logic                rot_a_q, rot_a_d;
  logic                rot_b_q, rot_b_d;
  logic                press_q, press_d;
  logic                press_pulse_q, press_pulse_d;
  logic                release_pulse_q, release_pulse_d;
  logic [GLITCH_W-1:0] glitch_count_q, glitch_count_d;
  logic [1:0]          events;

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_chan_a (
    .clk(clk), .rst(rst), .raw(rot_a_raw), .level(level_a),
    .rise(ab_edges_unused[0]), .fall(ab_edges_unused[1]), .glitch(glitch_a)
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_chan_b (
    .clk(clk), .rst(rst), .raw(rot_b_raw), .level(level_b),
    .rise(ab_edges_unused[2]), .fall(ab_edges_unused[3]), .glitch(glitch_b)
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_chan_p (
    .clk(clk), .rst(rst), .raw(rot_press_raw), .level(level_p),
    .rise(rise_p), .fall(fall_p), .glitch(glitch_p)
  );

  // Output registers; everything leaving the block comes from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_a_q         <= 1'b0;
      rot_b_q         <= 1'b0;
      press_q         <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      glitch_count_q  <= '0;
    end else begin
      rot_a_q         <= rot_a_d;
      rot_b_q         <= rot_b_d;
      press_q         <= press_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      glitch_count_q  <= glitch_count_d;
    end
  end

  // Levels and press strobes are re-registered together so the pulses stay
  // aligned with the press level they describe. The glitch counter sums up
  // to three simultaneous events; a clear wins over that cycle's events.
  always_comb begin
    rot_a_d         = level_a;
    rot_b_d         = level_b;
    press_d         = level_p;
    press_pulse_d   = rise_p;
    release_pulse_d = fall_p;
    events          = {1'b0, glitch_a} + {1'b0, glitch_b} + {1'b0, glitch_p};
    if (clear_glitch) begin
      glitch_count_d = '0;
    end else begin
      glitch_count_d = sat_add_glitch(glitch_count_q, events);
    end
  end

  assign rot_a         = rot_a_q;
  assign rot_b         = rot_b_q;
  assign press         = press_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign glitch_count  = glitch_count_q;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Directed bench for rotary_input_conditioner with a 4-cycle hold time.
// Inputs change 1 time unit after a rising edge, so each change is first
// sampled by the following edge; outputs are checked at the same offset.
module tb_rotary_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       rot_a_raw, rot_b_raw, rot_press_raw, clear_glitch;
  logic       rot_a, rot_b, press, press_pulse, release_pulse;
  logic [7:0] glitch_count;

  int checks = 0;
  int errors = 0;

  rotary_input_conditioner #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rot_a_raw(rot_a_raw), .rot_b_raw(rot_b_raw),
    .rot_press_raw(rot_press_raw), .clear_glitch(clear_glitch),
    .rot_a(rot_a), .rot_b(rot_b), .press(press),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic b, input logic p, input logic clr);
    rot_a_raw     = a;
    rot_b_raw     = b;
    rot_press_raw = p;
    clear_glitch  = clr;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      $error("[TB] %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Full output snapshot against expected values.
  task automatic check_all(input string tag, input logic a, input logic b, input logic p,
                           input logic pp, input logic rp, input logic [7:0] gc);
    check_output({tag, ".rot_a"}, {7'd0, rot_a}, {7'd0, a});
    check_output({tag, ".rot_b"}, {7'd0, rot_b}, {7'd0, b});
    check_output({tag, ".press"}, {7'd0, press}, {7'd0, p});
    check_output({tag, ".press_pulse"}, {7'd0, press_pulse}, {7'd0, pp});
    check_output({tag, ".release_pulse"}, {7'd0, release_pulse}, {7'd0, rp});
    check_output({tag, ".glitch_count"}, glitch_count, gc);
  endtask

  initial begin
    // 1: reset with all pins high, then levels rise at r+6
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick(3);
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    tick(6);
    check_all("post_reset_r5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    check_all("post_reset_r6", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    tick(1);
    check_all("post_reset_r7", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // Return all pins low and let everything settle.
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(10);
    check_all("all_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 2: rot_a rises exactly 6 edges after its first sample
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    check_all("a_rise_r5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    check_all("a_rise_r6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 3: rot_b high for only 3 samples is rejected as one glitch
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    check_all("b_glitch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // 4: press held 10 cycles gives one press and one release pulse
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(6);
    check_all("press_r5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tick(1);
    check_all("press_r6", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
    tick(1);
    check_all("press_r7", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    tick(2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    check_all("release_r5", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    tick(1);
    check_all("release_r6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    tick(1);
    check_all("release_r7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // 5a: 300 one-cycle dips on A saturate the counter
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1);
    end
    tick(4);
    check_all("saturate", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);

    // 5b: clear, count 10, then a simultaneous A+B glitch adds 2
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("clear_idle", glitch_count, 8'd0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1);
    end
    tick(4);
    check_output("count_10", glitch_count, 8'd10);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(4);
    check_all("dual_glitch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd12);

    // 5c: clear lands in the same cycle as a glitch event
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("clear_on_event", glitch_count, 8'd0);
    tick(3);
    check_output("clear_on_event_after", glitch_count, 8'd0);

    // 6: reset while A is pending at cnt = 2 aborts the debounce
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(1);
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    check_all("fresh_r5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    check_all("fresh_r6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
